stream_min_max_tracker: RTL
===========================

// Module: stream_min_max_tracker
// PURPOSE
//  Consumer side of the magnitude-compare path: accepts a valid/ready stream of unsigned
//  words framed by s_last, compares each word against the running extremes, and emits
//  one result per frame (min, max, beat count) on a valid/ready output port.
//  Sits after any sample source; the result feeds a control/status reader.
// PARAMETERS
//  width = 8   data word width (unsigned)
//  CNT_W = 16  beat-counter width; count saturates at 2^CNT_W-1
// PORTS
//  clk      in   1      single clock, rising edge
//  reset_n  in   1      asynchronous active-low reset
//  clr      in   1      sync abort: discard partial frame / pending result
//  s_data   in   width  input word
//  s_valid  in   1      input beat valid
//  s_last   in   1      beat is last of frame (qualified by s_valid & s_ready)
//  s_ready  out  1      block can accept a beat
//  m_valid  out  1      frame result valid
//  m_ready  in   1      result consumer ready
//  min_out  out  width  smallest word of frame
//  max_out  out  width  largest word of frame
//  count    out  CNT_W  beats in frame (saturating)
//  ovf      out  1      count saturated during this frame
// BEHAVIOUR
//  - Reset: async on reset_n low; state=EMPTY; m_valid, min_out, max_out, count, ovf = 0.
//  - Beat accepted when s_valid & s_ready. s_ready = (state != DONE); combinational from state only.
//  - States:
//    EMPTY: first beat loads min=max=s_data, count=1, ovf=0; s_last -> DONE, else -> ACCUM.
//    ACCUM: per beat min = (s_data < min) ? s_data : min; max = (s_data > max) ? s_data : max.
//      Ties keep the held value. count+1 saturating; ovf set (sticky) on any attempt past
//      all-ones. s_last -> DONE.
//    DONE: m_valid=1, s_ready=0; min_out/max_out/count/ovf held stable.
//      m_valid & m_ready -> EMPTY.
//  - Latency: last beat accepted at edge N -> m_valid=1 after edge N; single-beat frame is legal.
//  - Back-to-back frames: the first beat of the next frame is accepted no earlier than
//    the cycle after the m_ready handshake (one bubble cycle).
//  - clr (sync, highest priority over beats/handshake): -> EMPTY, m_valid=0 next cycle;
//    a beat presented with clr is dropped; result registers keep their values.
//  - Result registers update only on accepted beats; m_valid never drops without a
//    handshake except via clr or reset.
//  - Reset mid-frame or in DONE: partial frame/result lost; m_valid=0 immediately.
//  - No X propagation: s_data is ignored when s_valid=0.
// CONFIGURATION
//  MINMAX_IDX_EN defined: adds outputs min_idx, max_idx (CNT_W, out): 0-based beat index of
//    the FIRST occurrence of min/max in the frame. Both 0 on the first beat. The index
//    counter saturates with count. Reset value 0; held in DONE.
//  MINMAX_IDX_EN undefined: ports and index logic absent; all other behaviour identical.
// TESTING
//  1. Frame 5,3,9,3,7 (last on 7) -> min_out=3, max_out=9, count=5, ovf=0;
//     idx build: min_idx=1, max_idx=2.
//  2. Single beat 0x80 with s_last -> m_valid=1 next cycle, min_out=max_out=0x80, count=1.
//  3. DONE with m_ready low 4 cycles, s_valid=1 s_data=0x11 -> s_ready=0, outputs stable;
//     after handshake, 0x11 is the next frame's first beat.
//  4. Two beats then clr, then 0x42 with last -> min_out=max_out=0x42, count=1.
//  5. CNT_W=3, 9-beat frame -> count=7, ovf=1; next frame ovf=0.
//  6. reset_n pulsed low while in DONE -> m_valid=0 asynchronously, all outputs 0, s_ready=1.

Source files
------------

// File: rtl/stream_min_max_tracker.sv
// stream_min_max_tracker: per-frame min/max/beat-count of an unsigned valid/ready stream.
// Define MINMAX_IDX_EN to add min_idx/max_idx outputs (first-occurrence beat index).
module stream_min_max_tracker #(
    parameter int width = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [width-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [width-1:0] min_out,
    output logic [width-1:0] max_out,
    output logic [CNT_W-1:0] count,
    output logic             ovf
`ifdef MINMAX_IDX_EN
    ,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx
`endif
);
    typedef enum logic [1:0] {EMPTY, ACCUM, DONE} state_t;
    state_t state;
    assign s_ready = state != DONE;
    // Within EMPTY/ACCUM s_ready is 1, so s_valid alone qualifies a beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            min_out <= '0;
            max_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
`ifdef MINMAX_IDX_EN
            min_idx <= '0;
            max_idx <= '0;
`endif
        end else if (clr) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (s_valid) begin
                    min_out <= s_data;
                    max_out <= s_data;
                    count   <= CNT_W'(1);
                    ovf     <= 1'b0;
`ifdef MINMAX_IDX_EN
                    min_idx <= '0;
                    max_idx <= '0;
`endif
                    state   <= s_last ? DONE : ACCUM;
                    m_valid <= s_last;
                end
                ACCUM: if (s_valid) begin
                    min_out <= (s_data < min_out) ? s_data : min_out;
                    max_out <= (s_data > max_out) ? s_data : max_out;
`ifdef MINMAX_IDX_EN
                    // The held count equals this beat's 0-based index and saturates with it.
                    min_idx <= (s_data < min_out) ? count : min_idx;
                    max_idx <= (s_data > max_out) ? count : max_idx;
`endif
                    count   <= (&count) ? count : count + CNT_W'(1);
                    ovf     <= ovf | (&count);
                    state   <= s_last ? DONE : ACCUM;
                    m_valid <= s_last;
                end
                DONE: if (m_ready) begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
